// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared widths, sweep-mode and FSM-state encodings for the NCO sweep controller.
package nco_sweep_ctrl_pkg;

  localparam int FW_DEF = 6;
  localparam int PW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_SAW     = 2'b01,
    MODE_TRI     = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Encoding 11 behaves as a one-shot sweep.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = MODE_SAW;
      2'b10:   decode_mode = MODE_TRI;
      default: decode_mode = MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Host-side configuration/start bus of the sweep controller, plus the abort request.
interface nco_sweep_ctrl_if
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [FW-1:0] cfg_f_start;
  logic [FW-1:0] cfg_f_stop;
  logic [FW-1:0] cfg_f_step;
  logic [DW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_phase;
  logic [1:0]    cfg_mode;
  logic          stop_req;

  modport master (
    output cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_phase, cfg_mode, stop_req,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_phase, cfg_mode, stop_req,
    output cfg_ready
  );
endinterface

// File: rtl/nco_sweep_ctrl_step_calc.sv
// Combinational next-frequency: one clamped step toward the end point, or toward the
// start point when already sitting on the end (used by triangle reversal).
module nco_sweep_ctrl_step_calc #(
  parameter int FW = 6
) (
  input  logic [FW-1:0] cur_i,
  input  logic [FW-1:0] start_i,
  input  logic [FW-1:0] end_i,
  input  logic [FW-1:0] step_i,
  output logic [FW-1:0] next_o,
  output logic          at_end_o
);
  logic [FW-1:0] target;
  logic [FW:0]   sum;
  logic [FW:0]   diff;

  always_comb begin
    at_end_o = (cur_i == end_i);
    target   = at_end_o ? start_i : end_i;
    sum      = {1'b0, cur_i} + {1'b0, step_i};
    diff     = {1'b0, cur_i} - {1'b0, step_i};
    next_o   = target;
    // Extra top bit catches overflow (sum) and underflow (borrow in diff) before clamping.
    if (target >= cur_i) begin
      if (sum < {1'b0, target}) next_o = sum[FW-1:0];
    end else if (!diff[FW] && (diff[FW-1:0] > target)) begin
      next_o = diff[FW-1:0];
    end
  end
endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO sweep sequencer: latches a sweep config, primes the nco, then steps freq_res
// with a fixed dwell per value in one-shot, sawtooth or triangle fashion.
module nco_sweep_ctrl
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  nco_sweep_ctrl_if.slave cfg_if,
  output logic [FW-1:0] freq_res_o,
  output logic [PW-1:0] phase_o,
  output logic          nco_rst_o,
  output logic          busy_o,
  output logic          done_o
);
  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          nco_rst_q, nco_rst_d;
  logic [FW-1:0] start_q, start_d;
  logic [FW-1:0] end_q, end_d;
  logic [FW-1:0] step_q, step_d;
  logic [DW-1:0] dwell_m1_q, dwell_m1_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] calc_next;
  logic          at_end;

  nco_sweep_ctrl_step_calc #(.FW(FW)) u_step_calc (
    .cur_i    (freq_q),
    .start_i  (start_q),
    .end_i    (end_q),
    .step_i   (step_q),
    .next_o   (calc_next),
    .at_end_o (at_end)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    nco_rst_d  = nco_rst_q;
    start_d    = start_q;
    end_d      = end_q;
    step_d     = step_q;
    dwell_m1_d = dwell_m1_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_if.cfg_valid) begin
          state_d    = ST_PRIME;
          mode_d     = decode_mode(cfg_if.cfg_mode);
          freq_d     = cfg_if.cfg_f_start;
          phase_d    = cfg_if.cfg_phase;
          nco_rst_d  = 1'b1;
          start_d    = cfg_if.cfg_f_start;
          end_d      = cfg_if.cfg_f_stop;
          step_d     = (cfg_if.cfg_f_step == '0) ? FW'(1) : cfg_if.cfg_f_step;
          dwell_m1_d = (cfg_if.cfg_dwell == '0) ? '0 : cfg_if.cfg_dwell - DW'(1);
        end
      end
      ST_PRIME: begin
        nco_rst_d = 1'b0;
        cnt_d     = dwell_m1_q;
        state_d   = cfg_if.stop_req ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (cfg_if.stop_req) begin
          state_d = ST_DONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (at_end) begin
          cnt_d = dwell_m1_q;
          case (mode_q)
            MODE_SAW: freq_d = start_q;
            MODE_TRI: begin
              // calc_next already heads back toward start_q; swap endpoints to match.
              freq_d  = calc_next;
              start_d = end_q;
              end_d   = start_q;
            end
            default:  state_d = ST_DONE;
          endcase
        end else begin
          freq_d = calc_next;
          cnt_d  = dwell_m1_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ONESHOT;
      freq_q     <= '0;
      phase_q    <= '0;
      nco_rst_q  <= 1'b1;
      start_q    <= '0;
      end_q      <= '0;
      step_q     <= FW'(1);
      dwell_m1_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      nco_rst_q  <= nco_rst_d;
      start_q    <= start_d;
      end_q      <= end_d;
      step_q     <= step_d;
      dwell_m1_q <= dwell_m1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cfg_if.cfg_ready = (state_q == ST_IDLE);
  assign freq_res_o       = freq_q;
  assign phase_o          = phase_q;
  assign nco_rst_o        = nco_rst_q;
  assign busy_o           = (state_q == ST_PRIME) || (state_q == ST_RUN);
  assign done_o           = (state_q == ST_DONE);
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: hand-computed frequency sequences per sweep mode.
module tb_nco_sweep_ctrl;
  import nco_sweep_ctrl_pkg::*;

  localparam int FW = FW_DEF;
  localparam int PW = PW_DEF;
  localparam int DW = DW_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] freq_res;
  logic [PW-1:0] phase;
  logic          nco_rst;
  logic          busy;
  logic          done;
  logic [3:0]    stat;
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  nco_sweep_ctrl_if #(.FW(FW), .PW(PW), .DW(DW)) cfg_bus ();

  nco_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_if     (cfg_bus),
    .freq_res_o (freq_res),
    .phase_o    (phase),
    .nco_rst_o  (nco_rst),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Status nibble {nco_rst, busy, done, cfg_ready}: IDLE-reset 1001, PRIME 1100, RUN 0100, DONE 0010, IDLE 0001.
  assign stat = {nco_rst, busy, done, cfg_bus.cfg_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fe, input logic [FW-1:0] st,
                             input logic [DW-1:0] dw, input logic [PW-1:0] ph, input logic [1:0] md);
    cfg_bus.cfg_f_start = fs;
    cfg_bus.cfg_f_stop  = fe;
    cfg_bus.cfg_f_step  = st;
    cfg_bus.cfg_dwell   = dw;
    cfg_bus.cfg_phase   = ph;
    cfg_bus.cfg_mode    = md;
    cfg_bus.cfg_valid   = 1'b1;
    tick();
    cfg_bus.cfg_valid   = 1'b0;
    $display("sweep start f_start=%0d f_stop=%0d step=%0d dwell=%0d mode=%0d", fs, fe, st, dw, md);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(0), PW'(0), 4'b1001})
      $display("FAIL reset: freq=%0d phase=%0h stat=%b, required 0 0 1001", freq_res, phase, stat);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (stat !== 4'b1001) $display("FAIL reset_hold: stat=%b, required 1001", stat);
    else pass_cnt++;
  endtask

  task automatic test_oneshot_up();
    int seq[$];
    seq = '{1, 1, 1, 5, 5, 5, 9, 9, 9, 10, 10, 10};
    start_sweep(6'd1, 6'd10, 6'd4, 16'd3, 8'h23, 2'b00);
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(1), 8'h23, 4'b1100})
      $display("FAIL oneshot_prime: freq=%0d phase=%0h stat=%b, required 1 23 1100", freq_res, phase, stat);
    else pass_cnt++;
    foreach (seq[i]) begin
      tick();
      chk_cnt++;
      if ({freq_res, stat} !== {FW'(seq[i]), 4'b0100})
        $display("FAIL oneshot_run[%0d]: freq=%0d stat=%b, required %0d 0100", i, freq_res, stat, seq[i]);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(10), 4'b0010})
      $display("FAIL oneshot_done: freq=%0d stat=%b, required 10 0010", freq_res, stat);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(10), 8'h23, 4'b0001})
      $display("FAIL oneshot_idle: freq=%0d phase=%0h stat=%b, required 10 23 0001", freq_res, phase, stat);
    else pass_cnt++;
  endtask

  task automatic test_down_clamp();
    int seq[$];
    seq = '{61, 45, 29, 15};
    start_sweep(6'd61, 6'd15, 6'd16, 16'd1, 8'h00, 2'b00);
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(61), 4'b1100})
      $display("FAIL down_prime: freq=%0d stat=%b, required 61 1100", freq_res, stat);
    else pass_cnt++;
    foreach (seq[i]) begin
      tick();
      chk_cnt++;
      if ({freq_res, stat} !== {FW'(seq[i]), 4'b0100})
        $display("FAIL down_run[%0d]: freq=%0d stat=%b, required %0d 0100", i, freq_res, stat, seq[i]);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(15), 4'b0010})
      $display("FAIL down_done: freq=%0d stat=%b, required 15 0010", freq_res, stat);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_triangle_stop();
    int seq[$];
    seq = '{15, 15, 23, 23, 31, 31, 23, 23, 15, 15, 23};
    start_sweep(6'd15, 6'd31, 6'd8, 16'd2, 8'h5a, 2'b10);
    foreach (seq[i]) begin
      tick();
      chk_cnt++;
      if ({freq_res, stat} !== {FW'(seq[i]), 4'b0100})
        $display("FAIL tri_run[%0d]: freq=%0d stat=%b, required %0d 0100", i, freq_res, stat, seq[i]);
      else pass_cnt++;
    end
    cfg_bus.stop_req = 1'b1;
    tick();
    cfg_bus.stop_req = 1'b0;
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(23), 8'h5a, 4'b0010})
      $display("FAIL tri_stop: freq=%0d phase=%0h stat=%b, required 23 5a 0010", freq_res, phase, stat);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(23), 4'b0001})
      $display("FAIL tri_idle: freq=%0d stat=%b, required 23 0001", freq_res, stat);
    else pass_cnt++;
  endtask

  task automatic test_sawtooth();
    int seq[$];
    seq = '{1, 2, 3, 1, 2, 3, 1};
    start_sweep(6'd1, 6'd3, 6'd0, 16'd0, 8'h00, 2'b01);
    foreach (seq[i]) begin
      tick();
      chk_cnt++;
      if ({freq_res, stat} !== {FW'(seq[i]), 4'b0100})
        $display("FAIL saw_run[%0d]: freq=%0d stat=%b, required %0d 0100", i, freq_res, stat, seq[i]);
      else pass_cnt++;
    end
    cfg_bus.stop_req = 1'b1;
    tick();
    cfg_bus.stop_req = 1'b0;
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(1), 4'b0010})
      $display("FAIL saw_stop: freq=%0d stat=%b, required 1 0010", freq_res, stat);
    else pass_cnt++;
    tick();
    start_sweep(6'd63, 6'd63, 6'd5, 16'd0, 8'h11, 2'b01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++;
      if ({freq_res, stat} !== {FW'(63), 4'b0100})
        $display("FAIL saw_hold[%0d]: freq=%0d stat=%b, required 63 0100", i, freq_res, stat);
      else pass_cnt++;
    end
    cfg_bus.stop_req = 1'b1;
    tick();
    cfg_bus.stop_req = 1'b0;
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(63), 4'b0010})
      $display("FAIL saw_hold_stop: freq=%0d stat=%b, required 63 0010", freq_res, stat);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_busy_cfg();
    start_sweep(6'd0, 6'd20, 6'd1, 16'd5, 8'h44, 2'b00);
    tick();
    tick();
    cfg_bus.cfg_f_start = 6'd50;
    cfg_bus.cfg_f_step  = 6'd7;
    cfg_bus.cfg_dwell   = 16'd1;
    cfg_bus.cfg_phase   = 8'hee;
    cfg_bus.cfg_valid   = 1'b1;
    chk_cnt++;
    if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL busy_ready: cfg_ready=%b, required 0", cfg_bus.cfg_ready);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) tick();
    cfg_bus.cfg_valid = 1'b0;
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(1), 8'h44, 4'b0100})
      $display("FAIL busy_ignore: freq=%0d phase=%0h stat=%b, required 1 44 0100", freq_res, phase, stat);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(0), PW'(0), 4'b1001})
      $display("FAIL mid_rst: freq=%0d phase=%0h stat=%b, required 0 0 1001", freq_res, phase, stat);
    else pass_cnt++;
    start_sweep(6'd7, 6'd7, 6'd3, 16'd2, 8'h99, 2'b11);
    chk_cnt++;
    if ({freq_res, phase, stat} !== {FW'(7), 8'h99, 4'b1100})
      $display("FAIL post_rst_prime: freq=%0d phase=%0h stat=%b, required 7 99 1100", freq_res, phase, stat);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_cnt++;
      if ({freq_res, stat} !== {FW'(7), 4'b0100})
        $display("FAIL equal_run[%0d]: freq=%0d stat=%b, required 7 0100", i, freq_res, stat);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if ({freq_res, stat} !== {FW'(7), 4'b0010})
      $display("FAIL equal_done: freq=%0d stat=%b, required 7 0010", freq_res, stat);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    cfg_bus.cfg_valid   = 1'b0;
    cfg_bus.cfg_f_start = '0;
    cfg_bus.cfg_f_stop  = '0;
    cfg_bus.cfg_f_step  = '0;
    cfg_bus.cfg_dwell   = '0;
    cfg_bus.cfg_phase   = '0;
    cfg_bus.cfg_mode    = 2'b00;
    cfg_bus.stop_req    = 1'b0;
    test_reset();
    test_oneshot_up();
    test_down_clamp();
    test_triangle_stop();
    test_sawtooth();
    test_busy_cfg();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
